// File: rtl/axppa_error_monitor.sv
// ---------------------------------------------------------------------------
// axppa_error_monitor
//
// Streaming error-characterisation stage for a WIDTH-bit approximate
// parallel-prefix adder. Each accepted sample (in_a, in_b, in_cin,
// in_sum_approx) is compared with the exact WIDTH-bit sum. Over a run of
// num_samples samples the block accumulates:
//   - sample_count : samples accumulated
//   - err_count    : samples whose error distance is nonzero
//   - sum_ed       : saturating sum of error distances (gives MED)
//   - max_ed       : worst-case error distance (WCE)
// and then pulses done for one cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a run (only honoured in IDLE)
//   num_samples       run length, latched on start
//   in_valid/in_ready sample handshake; transfer on in_valid & in_ready
//   in_a, in_b, in_cin operands presented to the approximate adder
//   in_sum_approx     sum the approximate adder produced
//   busy              high while running or draining the pipeline
//   done              one-cycle pulse, results valid
//   sample_count, err_count, sum_ed, max_ed   run results
//
// Pipeline: S1 captures the error distance on transfer, S2 forwards it,
// and the result registers fold it in on the following edge, so a sample
// transferred at edge E is visible on the outputs after edge E+2.
// ---------------------------------------------------------------------------
module axppa_error_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_sum_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [WIDTH-1:0] max_ed
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [ACC_W-1:0] ACC_ONES = {ACC_W{1'b1}};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

    // Unsigned magnitude of (exact - approx); the exact sum is truncated to
    // WIDTH bits because the approximate adder has no carry-out to compare.
    function automatic logic [WIDTH-1:0] err_distance(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             cin,
        input logic [WIDTH-1:0] approx
    );
        logic [WIDTH-1:0] exact;
        exact = a + b + {{(WIDTH-1){1'b0}}, cin};
        if (exact >= approx) begin
            err_distance = exact - approx;
        end else begin
            err_distance = approx - exact;
        end
    endfunction

    // Saturating accumulate: an extra top bit catches the overflow.
    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0] acc,
        input logic [WIDTH-1:0] ed
    );
        logic [ACC_W:0] ext;
        ext = {1'b0, acc} + {{(ACC_W+1-WIDTH){1'b0}}, ed};
        if (ext[ACC_W]) begin
            sat_add = ACC_ONES;
        end else begin
            sat_add = ext[ACC_W-1:0];
        end
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] num_lat_r;
    logic [CNT_W-1:0] accepted_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             done_r;

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_ed_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_ed_r;

    logic [CNT_W-1:0] sample_count_r;
    logic [CNT_W-1:0] err_count_r;
    logic [ACC_W-1:0] sum_ed_r;
    logic [WIDTH-1:0] max_ed_r;

    logic             xfer_s;
    logic             clear_s;
    logic [WIDTH-1:0] ed_s;
    logic [CNT_W-1:0] accepted_inc_s;

    // Handshake decode, run-start decode and S1 error distance.
    always_comb begin
        xfer_s         = in_valid & in_ready_r;
        clear_s        = (state_r == ST_IDLE) & start;
        ed_s           = err_distance(in_a, in_b, in_cin, in_sum_approx);
        accepted_inc_s = accepted_r + CNT_ONE;
    end

    // Run-control FSM with registered in_ready / busy / done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            num_lat_r  <= CNT_ZERO;
            accepted_r <= CNT_ZERO;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        num_lat_r  <= num_samples;
                        accepted_r <= CNT_ZERO;
                        in_ready_r <= (num_samples != CNT_ZERO);
                        busy_r     <= 1'b1;
                        state_r    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (xfer_s) begin
                        accepted_r <= accepted_inc_s;
                        // Drop in_ready on the edge of the final transfer.
                        if (accepted_inc_s >= num_lat_r) begin
                            in_ready_r <= 1'b0;
                            state_r    <= ST_DRAIN;
                        end
                    end else if (accepted_r >= num_lat_r) begin
                        // Only reachable for a zero-length run.
                        in_ready_r <= 1'b0;
                        state_r    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid_r && !s2_valid_r) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-stage sample pipeline; it never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_ed_r    <= W_ZERO;
            s2_valid_r <= 1'b0;
            s2_ed_r    <= W_ZERO;
        end else begin
            s1_valid_r <= xfer_s;
            if (xfer_s) begin
                s1_ed_r <= ed_s;
            end
            s2_valid_r <= s1_valid_r;
            s2_ed_r    <= s1_ed_r;
        end
    end

    // Result registers: cleared on start, updated by each sample leaving S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count_r <= CNT_ZERO;
            err_count_r    <= CNT_ZERO;
            sum_ed_r       <= ACC_ZERO;
            max_ed_r       <= W_ZERO;
        end else if (clear_s) begin
            sample_count_r <= CNT_ZERO;
            err_count_r    <= CNT_ZERO;
            sum_ed_r       <= ACC_ZERO;
            max_ed_r       <= W_ZERO;
        end else if (s2_valid_r) begin
            sample_count_r <= sample_count_r + CNT_ONE;
            if (s2_ed_r != W_ZERO) begin
                err_count_r <= err_count_r + CNT_ONE;
            end
            sum_ed_r <= sat_add(sum_ed_r, s2_ed_r);
            if (s2_ed_r > max_ed_r) begin
                max_ed_r <= s2_ed_r;
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign sample_count = sample_count_r;
    assign err_count    = err_count_r;
    assign sum_ed       = sum_ed_r;
    assign max_ed       = max_ed_r;

endmodule

// File: tb/tb_axppa_error_monitor.sv
// ---------------------------------------------------------------------------
// tb_axppa_error_monitor
//
// Directed bench for axppa_error_monitor. Two instances share the stimulus:
// the default configuration and one with a 17-bit accumulator so that
// sum_ed saturation is reachable in four samples. Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_axppa_error_monitor;

    localparam int WIDTH = 16;
    localparam int CNT_W = 32;
    localparam int ACC_W = 48;
    localparam int SAT_W = 17;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [WIDTH-1:0] in_sum_approx;

    logic             in_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] sum_ed;
    logic [WIDTH-1:0] max_ed;

    logic             sat_in_ready;
    logic             sat_busy;
    logic             sat_done;
    logic [CNT_W-1:0] sat_sample_count;
    logic [CNT_W-1:0] sat_err_count;
    logic [SAT_W-1:0] sat_sum_ed;
    logic [WIDTH-1:0] sat_max_ed;

    int n_checks;
    int n_fail;

    axppa_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_sum_approx(in_sum_approx), .busy(busy),
        .done(done), .sample_count(sample_count), .err_count(err_count),
        .sum_ed(sum_ed), .max_ed(max_ed)
    );

    axppa_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(SAT_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_sum_approx(in_sum_approx), .busy(sat_busy),
        .done(sat_done), .sample_count(sat_sample_count),
        .err_count(sat_err_count), .sum_ed(sat_sum_ed), .max_ed(sat_max_ed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [CNT_W-1:0] n);
        start       = 1'b1;
        num_samples = n;
        tick();
        start       = 1'b0;
    endtask

    // Present one sample and hold it until it transfers (bounded).
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [WIDTH-1:0] approx);
        int n;
        n             = 0;
        in_a          = a;
        in_b          = b;
        in_cin        = cin;
        in_sum_approx = approx;
        in_valid      = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("send_ready_timeout", {63'd0, in_ready}, 64'd1);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for done, then confirm it is a single-cycle pulse.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic done_clears(input string tag);
        tick();
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int xfers;
        logic saw_ready;
        logic saw_done;

        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        num_samples   = 32'd0;
        in_valid      = 1'b0;
        in_a          = 16'h0000;
        in_b          = 16'h0000;
        in_cin        = 1'b0;
        in_sum_approx = 16'h0000;

        // ---- reset state ----
        tick();
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_sample_count", 64'(sample_count), 64'd0);
        rst_n = 1'b1;
        tick();

        // ---- mid-run asynchronous reset ----
        start_run(32'd10);
        check("run_in_ready", {63'd0, in_ready}, 64'd1);
        check("run_busy", {63'd0, busy}, 64'd1);
        send(16'hFFFF, 16'h0000, 1'b0, 16'h0000);
        send(16'h0001, 16'h0001, 1'b0, 16'h0000);
        send(16'h0003, 16'h0000, 1'b0, 16'h0003);
        tick();
        tick();
        check("pre_rst_sample_count", 64'(sample_count), 64'd3);
        check("pre_rst_err_count", 64'(err_count), 64'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", {63'd0, in_ready}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_sample_count", 64'(sample_count), 64'd0);
        check("arst_err_count", 64'(err_count), 64'd0);
        check("arst_sum_ed", 64'(sum_ed), 64'd0);
        check("arst_max_ed", 64'(max_ed), 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("post_rst_busy", {63'd0, busy}, 64'd0);

        // ---- exact results, including the carry-out wrap case ----
        start_run(32'd4);
        send(16'h1234, 16'h0001, 1'b0, 16'h1235);
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000);
        send(16'h0000, 16'h0000, 1'b1, 16'h0001);
        send(16'h8000, 16'h8000, 1'b1, 16'h0001);
        check("exact_ready_drop", {63'd0, in_ready}, 64'd0);
        wait_done("exact");
        check("exact_sample_count", 64'(sample_count), 64'd4);
        check("exact_err_count", 64'(err_count), 64'd0);
        check("exact_sum_ed", 64'(sum_ed), 64'd0);
        check("exact_max_ed", 64'(max_ed), 64'd0);
        done_clears("exact");

        // ---- error accumulation and two-edge latency ----
        start_run(32'd2);
        check("err_start_clears_count", 64'(sample_count), 64'd0);
        send(16'h0010, 16'h0030, 1'b0, 16'h0030);   // exact 0x40, ed 16
        check("lat_e0_sample_count", 64'(sample_count), 64'd0);
        tick();
        check("lat_e1_sample_count", 64'(sample_count), 64'd0);
        tick();
        check("lat_e2_sample_count", 64'(sample_count), 64'd1);
        check("lat_e2_sum_ed", 64'(sum_ed), 64'd16);
        send(16'h00F0, 16'h0010, 1'b1, 16'h0101);   // exact 0x101, ed 0
        wait_done("err");
        check("err_sample_count", 64'(sample_count), 64'd2);
        check("err_err_count", 64'(err_count), 64'd1);
        check("err_sum_ed", 64'(sum_ed), 64'd16);
        check("err_max_ed", 64'(max_ed), 64'h10);
        done_clears("err");
        tick();
        check("err_results_hold", 64'(sum_ed), 64'd16);

        // ---- zero-length run ----
        saw_ready = 1'b0;
        saw_done  = 1'b0;
        start_run(32'd0);
        check("zero_start_clears_sum", 64'(sum_ed), 64'd0);
        check("zero_start_clears_max", 64'(max_ed), 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (in_ready) saw_ready = 1'b1;
            if (!saw_done) begin
                tick();
                if (done) saw_done = 1'b1;
            end
        end
        check("zero_in_ready_never", {63'd0, saw_ready}, 64'd0);
        check("zero_done_within_3", {63'd0, saw_done}, 64'd1);
        check("zero_sample_count", 64'(sample_count), 64'd0);
        check("zero_err_count", 64'(err_count), 64'd0);
        done_clears("zero");

        // ---- handshake: valid held high, start during RUN ignored ----
        start_run(32'd3);
        xfers         = 0;
        in_a          = 16'h0001;
        in_b          = 16'h0001;
        in_cin        = 1'b0;
        in_sum_approx = 16'h0003;                   // ed 1 per sample
        in_valid      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic this_xfer;
            this_xfer = in_valid & in_ready;
            if (i == 1) begin
                start       = 1'b1;
                num_samples = 32'd7;
            end else begin
                start = 1'b0;
            end
            if (this_xfer) xfers++;
            tick();
            if (this_xfer && xfers == 3) begin
                check("hs_ready_drop_on_3rd", {63'd0, in_ready}, 64'd0);
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("hs_transfer_count", 64'(xfers), 64'd3);
        wait_done("hs");
        check("hs_sample_count", 64'(sample_count), 64'd3);
        check("hs_err_count", 64'(err_count), 64'd3);
        check("hs_sum_ed", 64'(sum_ed), 64'd3);
        done_clears("hs");

        // ---- accumulator saturation (17-bit instance) ----
        start_run(32'd4);
        for (int i = 0; i < 4; i++) begin
            send(16'hFFFF, 16'h0000, 1'b0, 16'h0000); // ed 0xFFFF
        end
        wait_done("sat");
        check("sat_sum_ed_17", 64'(sat_sum_ed), 64'h1FFFF);
        check("sat_max_ed_17", 64'(sat_max_ed), 64'hFFFF);
        check("sat_err_count_17", 64'(sat_err_count), 64'd4);
        check("sat_done_17", {63'd0, sat_done}, 64'd1);
        check("sat_sum_ed_48", 64'(sum_ed), 64'h3FFFC);
        check("sat_max_ed_48", 64'(max_ed), 64'hFFFF);
        done_clears("sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axppa_error_monitor.md
Name: axppa_error_monitor

Overview:
- Streaming error-characterisation stage placed directly downstream of a WIDTH-bit approximate parallel-prefix adder (Ladner-Fischer/K-variant family).
- Consumes each operand set (A, B, Cin) together with the approximate Sum the adder produced, and recomputes the exact sum internally.
- Accumulates error metrics over a programmed run of samples: error count, sum of error distances and maximum error distance.
- Reports the results with a one-cycle done pulse, for ER/MED/WCE characterisation in benches and on FPGA.

Parameters:
- WIDTH, 16: adder operand and sum width.
- CNT_W, 32: width of the sample and error counters, and of num_samples.
- ACC_W, 48: width of the error-distance accumulator.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- num_samples  in  CNT_W  samples in the run; latched on start.
- in_valid  in  1  operand/result set valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in.
- in_sum_approx  in  WIDTH  Sum produced by the approximate adder for (in_a, in_b, in_cin).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse; results valid.
- sample_count  out  CNT_W  samples accumulated.
- err_count  out  CNT_W  samples with a nonzero error distance.
- sum_ed  out  ACC_W  sum of error distances; saturating.
- max_ed  out  WIDTH  largest error distance seen.

Behaviour:
- Reset (asynchronous, any state, including mid-run):
  - state=IDLE; all pipeline valid bits cleared.
  - in_ready=0, busy=0, done=0.
  - sample_count, err_count, sum_ed and max_ed all 0.
- States IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - on start=1: latch num_samples, clear all four result registers, go to RUN.
  - start in any other state is ignored.
- RUN:
  - in_ready = (accepted < latched num_samples).
  - A sample transfers on a cycle with in_valid & in_ready.
  - When the final sample transfers, or immediately if num_samples=0, go to DRAIN; in_ready=0 from that edge onward.
- Pipeline: two stages, no backpressure internally.
  - S1, registered on transfer:
    - exact = (in_a + in_b + in_cin), truncated to WIDTH bits.
    - ed = |exact - in_sum_approx|, computed as an unsigned WIDTH-bit magnitude.
    - The carry-out is excluded, since the approximate adder produces none.
  - S2, the edge after S1:
    - sample_count += 1.
    - err_count += (ed != 0).
    - sum_ed += ed, saturating at all-ones.
    - max_ed = max(max_ed, ed).
- Latency: a sample transferred at edge E is reflected in the outputs after edge E+2.
- DRAIN: wait until both pipeline valid bits are 0, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Result outputs hold their values until the next start or reset.
- busy=1 in RUN and DRAIN only.
- Counters do not wrap: sample_count cannot exceed num_samples, so err_count cannot exceed it either. Only sum_ed saturates.
- in_valid while in_ready=0 has no effect; data is not captured.
- in_valid may stay high indefinitely or toggle every cycle; gaps only stretch the run.

Test Plan:
- Reset check: assert rst_n=0 mid-RUN after 3 of 10 samples -> all outputs 0 immediately with no clock edge; after release, state is IDLE and in_ready=0.
- Exact results: num_samples=4, four exact pairs (0x1234+0x0001, 0xFFFF+0x0001 with approx 0x0000, etc.) -> done pulse once; sample_count=4, err_count=0, sum_ed=0, max_ed=0.
- Error accumulation: samples (0x0010, 0x0030, cin=0, approx 0x0030) and (0x00F0, 0x0010, cin=1, approx 0x0101) -> ed 16 and 0; expect err_count=1, sum_ed=16, max_ed=0x0010.
- Zero-length run: start with num_samples=0 -> in_ready never 1; done pulses within 3 cycles of start; results are all 0.
- Handshake: num_samples=3, in_valid held high for 6 cycles -> exactly 3 transfers; in_ready drops on the edge of the 3rd transfer; start pulses during RUN are ignored.
- Accumulator limits: ACC_W=17, 4 samples each with ed=0xFFFF -> sum_ed saturates at 0x1FFFF; max_ed=0xFFFF; err_count=4.
